// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared sizing helpers for the memory port arbiter
//
// Purpose: derives index and tag widths from the requester count so the top
// and the arbiter agree on them. The request payload struct depends on the
// top's width parameters, so it is declared inside mem_port_arb.
// Ports: none (package).

package mem_port_arb_pkg;

    // Number of requester index bits appended to the tag; zero for one requester.
    function automatic int calc_log_num_reqs(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 0;
    endfunction

    // Memory-side tag width: requester tag plus index bits.
    function automatic int calc_tag_out_width(input int tag_in_width, input int num_reqs);
        return tag_in_width + calc_log_num_reqs(num_reqs);
    endfunction

    // Width of the internal index signals. It is at least one bit, so a
    // single-requester build still has a legal index vector.
    function automatic int calc_idx_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arb_rr_arbiter.sv
// rtl/mem_port_arb_rr_arbiter.sv - round-robin arbiter with internal priority pointer
//
// Purpose: grants the first valid requester at or after rr_ptr, wrapping modulo
// NUM_REQS. The pointer moves to one past the winner only when advance is high.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   requests        per-requester request lines
//   advance         winner was accepted this cycle; move the pointer past it
//   grant_onehot    one-hot grant (all zero when nothing requests)
//   grant_idx       binary index of the winner
//   grant_valid     at least one requester is active

module rr_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = calc_idx_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0]      rr_ptr;
    logic [2*NUM_REQS-1:0] req_dbl;
    logic [NUM_REQS-1:0]   req_rot;
    int                    offset;

    // Rotate the request vector so that bit 0 corresponds to rr_ptr. The
    // lowest set bit of the rotated vector is the distance from the pointer
    // to the winner.
    always_comb begin
        req_dbl = {requests, requests};
        req_rot = NUM_REQS'(req_dbl >> rr_ptr);
        offset  = 0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = k;
            end
        end
        grant_valid  = |requests;
        grant_idx    = IDX_W'((int'(rr_ptr) + offset) % NUM_REQS);
        grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_idx) : '0;
    end

    // With a single requester the modulo keeps the pointer at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= IDX_W'((int'(grant_idx) + 1) % NUM_REQS);
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - shares one downstream memory port among NUM_REQS requesters
//
// Purpose: round-robin arbitration into a one-deep registered request stage.
// The winner index is appended below the requester tag. Responses are steered
// back combinationally by decoding those low tag bits.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req_*_in  (per requester)        valid/rw/addr/byteen/data/tag; req_ready_in is the accept
//   req_*_out (downstream)           registered request; req_tag_out = {tag, grant_idx}
//   req_ready_out                    downstream accept
//   rsp_valid_in/data_in/tag_in      downstream response; rsp_ready_in is the accept
//   rsp_valid_out/data_out/tag_out   per-requester response (data and tag broadcast)
//   rsp_ready_out                    per-requester response ready

module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_REQS      = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int DATA_SIZE     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int LOG_NUM_REQS  = calc_log_num_reqs(NUM_REQS),
    parameter int TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_REQS-1:0]                  req_valid_in,
    input  logic [NUM_REQS-1:0]                  req_rw_in,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]   req_byteen_in,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  req_data_in,
    input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]                  req_ready_in,

    output logic                                 req_valid_out,
    output logic                                 req_rw_out,
    output logic [ADDR_WIDTH-1:0]                req_addr_out,
    output logic [DATA_SIZE-1:0]                 req_byteen_out,
    output logic [DATA_WIDTH-1:0]                req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]             req_tag_out,
    input  logic                                 req_ready_out,

    input  logic                                 rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]                rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]             rsp_tag_in,
    output logic                                 rsp_ready_in,

    output logic [NUM_REQS-1:0]                  rsp_valid_out,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  rsp_data_out,
    output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] rsp_tag_out,
    input  logic [NUM_REQS-1:0]                  rsp_ready_out
);

    localparam int IDX_W = calc_idx_width(NUM_REQS);

    typedef struct packed {
        logic                     rw;
        logic [ADDR_WIDTH-1:0]    addr;
        logic [DATA_SIZE-1:0]     byteen;
        logic [DATA_WIDTH-1:0]    data;
        logic [TAG_OUT_WIDTH-1:0] tag;
    } req_pkt_t;

    logic                     stage_ready;
    logic                     fire;
    logic                     grant_valid;
    logic [NUM_REQS-1:0]      grant_onehot;
    logic [IDX_W-1:0]         grant_idx;
    logic [TAG_OUT_WIDTH-1:0] next_tag;
    logic                     out_valid_r;
    req_pkt_t                 next_pkt;
    req_pkt_t                 out_pkt_r;

    // ---------------------------------------------------------------- request path

    rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_valid_in),
        .advance      (fire),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    // The stage takes a new request whenever it is empty or being drained
    // this cycle, so back-to-back requests flow without a bubble.
    assign stage_ready  = !out_valid_r || req_ready_out;
    assign fire         = stage_ready && grant_valid;
    assign req_ready_in = stage_ready ? grant_onehot : '0;

    if (LOG_NUM_REQS > 0) begin : g_tag_idx
        assign next_tag = {req_tag_in[grant_idx], grant_idx[LOG_NUM_REQS-1:0]};
    end else begin : g_tag_pass
        assign next_tag = req_tag_in[grant_idx];
    end

    always_comb begin
        next_pkt.rw     = req_rw_in[grant_idx];
        next_pkt.addr   = req_addr_in[grant_idx];
        next_pkt.byteen = req_byteen_in[grant_idx];
        next_pkt.data   = req_data_in[grant_idx];
        next_pkt.tag    = next_tag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (fire) begin
            out_valid_r <= 1'b1;
        end else if (stage_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Payload is qualified by out_valid_r, so it carries no reset.
    always_ff @(posedge clk) begin
        if (fire) begin
            out_pkt_r <= next_pkt;
        end
    end

    assign req_valid_out  = out_valid_r;
    assign req_rw_out     = out_pkt_r.rw;
    assign req_addr_out   = out_pkt_r.addr;
    assign req_byteen_out = out_pkt_r.byteen;
    assign req_data_out   = out_pkt_r.data;
    assign req_tag_out    = out_pkt_r.tag;

    // --------------------------------------------------------------- response path

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp_data
        assign rsp_data_out[i] = rsp_data_in;
    end

    if (LOG_NUM_REQS > 0) begin : g_rsp_route
        logic [LOG_NUM_REQS-1:0] rsp_idx;
        logic                    rsp_idx_ok;

        assign rsp_idx    = rsp_tag_in[LOG_NUM_REQS-1:0];
        assign rsp_idx_ok = (32'(rsp_idx) < NUM_REQS);

        for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp_lane
            assign rsp_valid_out[i] = rsp_valid_in && (32'(rsp_idx) == i);
            assign rsp_tag_out[i]   = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
        end

        // An index with no requester behind it is accepted and dropped so the
        // downstream response queue cannot lock up on a corrupt tag.
        assign rsp_ready_in = rsp_idx_ok ? rsp_ready_out[rsp_idx] : 1'b1;

        rsp_idx_range_a: assert property (@(posedge clk) disable iff (reset)
            rsp_valid_in |-> rsp_idx_ok);
    end else begin : g_rsp_pass
        assign rsp_valid_out[0] = rsp_valid_in;
        assign rsp_tag_out[0]   = rsp_tag_in;
        assign rsp_ready_in     = rsp_ready_out[0];
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Shares one downstream memory port among NUM_REQS upstream requesters, such as several cache banks feeding one memory-width adapter.
- Request path: round-robin arbitration, then a registered output stage. The winner's index is appended to the low bits of the tag.
- Response path: responses are steered back to the originating requester by decoding those tag bits.
- Request side has 1-cycle latency; response side is combinational.

Parameters:
- NUM_REQS, 4, number of requesters; legal range 1..16.
- DATA_WIDTH, 512, data width in bits, same on all ports.
- DATA_SIZE, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 26, address width in bits, same on all ports.
- TAG_IN_WIDTH, 8, requester-side tag width.
- LOG_NUM_REQS, $clog2(NUM_REQS), number of index bits (0 when NUM_REQS==1).
- TAG_OUT_WIDTH, TAG_IN_WIDTH+LOG_NUM_REQS, memory-side tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_in  in  NUM_REQS  per-requester request valid
- req_rw_in  in  NUM_REQS  1 = write
- req_addr_in  in  NUM_REQS x ADDR_WIDTH  request address
- req_byteen_in  in  NUM_REQS x DATA_SIZE  byte enables
- req_data_in  in  NUM_REQS x DATA_WIDTH  write data
- req_tag_in  in  NUM_REQS x TAG_IN_WIDTH  request tag
- req_ready_in  out  NUM_REQS  per-requester accept
- req_valid_out  out  1  downstream request valid
- req_rw_out  out  1  downstream rw
- req_addr_out  out  ADDR_WIDTH  downstream address
- req_byteen_out  out  DATA_SIZE  downstream byte enables
- req_data_out  out  DATA_WIDTH  downstream data
- req_tag_out  out  TAG_OUT_WIDTH  {tag_in, grant_idx}
- req_ready_out  in  1  downstream accept
- rsp_valid_in  in  1  downstream response valid
- rsp_data_in  in  DATA_WIDTH  response data
- rsp_tag_in  in  TAG_OUT_WIDTH  response tag
- rsp_ready_in  out  1  response accept
- rsp_valid_out  out  NUM_REQS  per-requester response valid
- rsp_data_out  out  NUM_REQS x DATA_WIDTH  response data, broadcast to all requesters
- rsp_tag_out  out  NUM_REQS x TAG_IN_WIDTH  rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS], broadcast
- rsp_ready_out  in  NUM_REQS  per-requester response ready

Behaviour:
- Reset (async assert, released synchronously to clk):
  - rr_ptr=0, out_valid_r=0, so req_valid_out=0.
  - Output data/tag registers are not reset (don't-care while invalid).
- Stage-accept condition: stage_ready = !out_valid_r || req_ready_out. The stage sustains 1 request/cycle.
- Arbitration (combinational):
  - Grant = first i with req_valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - req_ready_in[i] = stage_ready && granted(i). At most one bit is high; all are 0 if no requester is valid.
- Request fire (req_valid_in[g] && req_ready_in[g]):
  - Output registers load rw/addr/byteen/data of requester g and tag {req_tag_in[g], g[LOG_NUM_REQS-1:0]}.
  - out_valid_r <= 1.
  - rr_ptr <= (g+1) mod NUM_REQS. Wrap-around: g = NUM_REQS-1 gives rr_ptr 0.
- No fire while stage_ready:
  - out_valid_r <= 0 if req_ready_out was high.
  - rr_ptr is unchanged.
- Stall (out_valid_r && !req_ready_out):
  - Output registers hold and all req_ready_in are 0.
  - Requesters must hold valid and payload stable; the grant may change while stalled.
- Simultaneous drain and load (req_ready_out=1 and a new fire in the same cycle): new payload loaded, out_valid_r stays 1. No bubble.
- Response routing:
  - idx = rsp_tag_in[LOG_NUM_REQS-1:0].
  - rsp_valid_out[i] = rsp_valid_in && (idx==i).
  - rsp_ready_in = rsp_ready_out[idx].
  - Responses are independent of the request path; order is preserved as given by downstream.
- Out-of-range idx (idx >= NUM_REQS):
  - rsp_ready_in=1 (response dropped), no rsp_valid_out asserted.
  - Simulation-only RUNTIME_ASSERT fires.
- NUM_REQS==1:
  - No index bits; req_tag_out = req_tag_in; response valid/ready pass straight through.
  - Registered stage retained; rr_ptr is a constant 0.
- Reset mid-operation: an in-flight output request is discarded. Responses in flight downstream are not tracked by this block.

Decomposition:
- Shared package: helper for computing LOG_NUM_REQS and TAG_OUT_WIDTH, and a request-payload struct {rw, addr, byteen, data, tag}.
- One natural sub-module, rr_arbiter, parameterised on NUM_REQS:
  - Inputs: requests, advance/enable.
  - Outputs: one-hot grant, grant index, grant valid.
  - Holds rr_ptr internally.

Test Plan:
- NUM_REQS=4; requesters 0..3 all valid continuously, req_ready_out=1; reset releases with rr_ptr=0.
  - Grants 0,1,2,3,0,1 on successive cycles.
  - req_tag_out low 2 bits follow the same sequence, 1 cycle after each grant.
- Only requester 2 valid, addr=0x1234, tag=0x5A.
  - Next cycle: req_valid_out=1, req_addr_out=0x1234, req_tag_out=0x5A<<2|2 = 0x16A.
  - rr_ptr becomes 3.
- Backpressure: req_ready_out=0 for 3 cycles with requesters 1 and 3 valid.
  - One request loaded, then req_ready_in=0000 and outputs stable for 3 cycles.
  - On release, the next grant is the other requester; no loss or duplication.
- Response with rsp_tag_in=0x16A, rsp_ready_out=0100.
  - rsp_valid_out=0100, rsp_tag_out[2]=0x5A, rsp_ready_in=1.
  - Repeat with rsp_ready_out=0000: rsp_ready_in=0.
- Async reset asserted mid-cycle while req_valid_out=1: req_valid_out drops immediately (before the next clk edge); after release, the first grant is to requester 0.
- NUM_REQS=1: tag 0x33 passes to req_tag_out=0x33 with 1-cycle latency; 1 request/cycle throughput with req_ready_out held at 1.
